dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder that serves load/store requests from the datapath
//  (address = aluout, store data = writedata, load data returned on readdata).
//  Models a multicycle memory with programmable wait states. Requests use a
//  valid/ready handshake; ~ready drives the core's stall.
//  Word-addressed internal array. Alignment and range checked per access.
// PARAMETERS
//  DEPTH   64  number of 32-bit words in the array
//  ADDR_W  6   word-index width, equal to log2(DEPTH)
//  WAIT    2   wait-state cycles inserted before each access completes (0..15)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   request present this cycle
//  req_we      in   1   1 = store, 0 = load
//  addr        in   32  byte address from the ALU result
//  wdata       in   32  store data (writedata)
//  ready       out  1   responder can accept a request; ~ready = stall
//  resp_valid  out  1   one-cycle pulse: access complete
//  rdata       out  32  load data (readdata), valid while resp_valid=1
//  err         out  1   with resp_valid: misaligned or out-of-range access
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, resp_valid=0, rdata=0, err=0, counter=0.
//   Array contents are not cleared by reset.
//  FSM states: IDLE, WAIT, RESP.
//  Handshake: a request is accepted on a rising edge with req_valid&&ready.
//   ready=1 only in IDLE. On acceptance, addr, req_we and wdata are latched;
//   inputs are don't-care afterwards.
//  IDLE:
//   - accept with WAIT>0 -> WAIT, counter<=WAIT-1
//   - accept with WAIT==0 -> RESP
//   - otherwise stay in IDLE
//  WAIT:
//   - counter!=0: decrement
//   - counter==0: perform the access, go to RESP
//  RESP: resp_valid=1 for exactly one cycle, then IDLE.
//  Latency: resp_valid rises WAIT+1 cycles after the accepting edge.
//   Issue interval is WAIT+2 cycles; no request is accepted during RESP.
//  Access rules:
//   - word index = latched addr[ADDR_W+1:2]
//   - misaligned: addr[1:0]!=0
//   - out of range: addr[31:ADDR_W+2]!=0
//   - error (either condition): err=1, no array write, rdata=0
//   - valid store: mem[idx]<=wdata on the edge entering RESP; rdata unchanged;
//     err=0
//   - valid load: rdata<=mem[idx] on the edge entering RESP; err=0
//  rdata and err hold their values outside RESP until the next response.
//  A store followed by a load to the same index returns the new data.
//  Reset mid-operation (WAIT or RESP): the transaction is aborted, no array
//   write occurs, outputs return to reset values, resp_valid does not pulse.
//  req_valid asserted while ready=0 is ignored. The requester holds the
//   request until it sees ready=1.
// TESTING
//  1. reset, WAIT=2: store addr=0x10 data=0xDEADBEEF -> ready low 3 cycles;
//     resp_valid pulses 3 cycles after accept; err=0.
//  2. load addr=0x10 after test 1 -> rdata=0xDEADBEEF with resp_valid; err=0.
//  3. load addr=0x13 (misaligned) -> err=1, rdata=0; mem[4] unchanged
//     (re-read gives 0xDEADBEEF).
//  4. store addr=0x100 (out of range, DEPTH=64) -> err=1; mem[0] not
//     corrupted.
//  5. store addr=0x20 data=0x12345678, then assert reset during WAIT ->
//     no resp_valid; later load 0x20 returns the prior value.
//  6. WAIT=0: back-to-back loads with req_valid held high -> accepted every
//     2nd cycle; resp_valid 1 cycle after each accept.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath and the data-memory responder.
// A request transfers on a rising clk edge where req_valid && ready; the
// requester holds req_valid/req_we/addr/wdata stable until that edge, and
// resp_valid is a single-cycle pulse qualifying rdata and err.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, req_we, addr, wdata,
        input  ready, resp_valid, rdata, err
    );

    modport slave (
        input  req_valid, req_we, addr, wdata,
        output ready, resp_valid, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states; one outstanding
// access at a time, alignment/range checked, ~ready stalls the core.
module dmem_responder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [31:0]       addr_q, wdata_q;
    logic              we_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              do_access;
    logic [31:0]       acc_addr, acc_wdata;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_err;

    assign accept = bus.req_valid && (state == ST_IDLE);

    // With WAIT==0 the access happens on the accepting edge itself, so the
    // live bus values are used instead of the (not yet loaded) latches.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        if (state == ST_IDLE) begin
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_we    = bus.req_we;
        end
    end

    assign acc_idx = acc_addr[ADDR_W+1:2];
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        do_access = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_d   = ST_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    state_d   = ST_RESP;
                    do_access = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                we_q    <= bus.req_we;
            end
            if (do_access) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= 32'd0;
                end else if (!acc_we) begin
                    rdata_q <= mem[acc_idx];
                end
            end
        end
    end

    // Array is deliberately outside the reset domain; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!reset && do_access && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.ready      = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.rdata      = rdata_q;
    assign bus.err        = err_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT=2 instance for access rules and
// reset abort, WAIT=0 instance for back-to-back issue with req_valid held.
module tb_dmem_responder;

  localparam int WAIT_A = 2;

  logic clk;
  logic reset;
  logic [1:0] dbg_a, dbg_b;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  dmem_responder_if ifa();
  dmem_responder_if ifb();

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT(WAIT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .dbg_state(dbg_a)
  );

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .dbg_state(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one request on dut_a with cycle-by-cycle handshake checks
  task automatic req_a(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata);
    int n;
    logic [31:0] exp_r;
    @(negedge clk);
    ifa.req_valid = 1'b1;
    ifa.req_we    = we;
    ifa.addr      = addr;
    ifa.wdata     = wdata;
    n = 0;
    while (!ifa.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_pre"}, 32'(ifa.ready), 32'd1);
    @(posedge clk);
    #1;
    ifa.req_valid = 1'b0;
    ifa.req_we    = ~we;
    ifa.addr      = $urandom;
    ifa.wdata     = $urandom;
    exp_q.push_back(exp_rdata);
    for (int c = 1; c <= WAIT_A + 1; c++) begin
      @(negedge clk);
      check({tag, "_ready_busy"}, 32'(ifa.ready), 32'd0);
      check({tag, "_resp_valid"}, 32'(ifa.resp_valid), (c == WAIT_A + 1) ? 32'd1 : 32'd0);
    end
    exp_r = exp_q.pop_front();
    check({tag, "_err"}, 32'(ifa.err), 32'(exp_err));
    check({tag, "_rdata"}, ifa.rdata, exp_r);
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(ifa.ready), 32'd1);
    check({tag, "_resp_after"}, 32'(ifa.resp_valid), 32'd0);
    check({tag, "_rdata_hold"}, ifa.rdata, exp_r);
    check({tag, "_err_hold"}, 32'(ifa.err), 32'(exp_err));
  endtask

  logic        ops_we    [5];
  logic [31:0] ops_addr  [5];
  logic [31:0] ops_wdata [5];
  logic [31:0] ops_exp   [5];

  initial begin
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ifa.ready), 32'd1);
    check("rst_resp", 32'(ifa.resp_valid), 32'd0);
    check("rst_rdata", ifa.rdata, 32'd0);
    check("rst_err", 32'(ifa.err), 32'd0);
    check("rst_state", 32'(dbg_a), 32'd0);
    reset = 1'b0;

    // preload words the later error cases must leave intact
    req_a("pre0", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'd0);
    req_a("pre20", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'd0);

    req_a("t1_store", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0);
    req_a("t2_load", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
    req_a("t3_misal", 1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'd0);
    req_a("t3_reread", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
    req_a("t4_oor", 1'b1, 32'h0000_0100, 32'h5555_5555, 1'b1, 32'd0);
    req_a("t4_mem0", 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'hA5A5_A5A5);
    req_a("oor_hi", 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'd0);
    req_a("top_store", 1'b1, 32'h0000_00FC, 32'h0F0F_0F0F, 1'b0, 32'd0);
    req_a("top_load", 1'b0, 32'h0000_00FC, 32'h0, 1'b0, 32'h0F0F_0F0F);

    // reset while the store is waiting
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1;
    ifa.addr = 32'h0000_0020; ifa.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    ifa.req_valid = 1'b0;
    @(negedge clk);
    check("t5_in_wait", 32'(dbg_a), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_ready", 32'(ifa.ready), 32'd1);
    check("t5_rst_state", 32'(dbg_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_resp", 32'(ifa.resp_valid), 32'd0);
    end
    reset = 1'b0;
    check("t5_rdata_rst", ifa.rdata, 32'd0);
    req_a("t5_load", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hCAFE_F00D);

    // WAIT=0 back-to-back with req_valid held high
    ops_we[0] = 1'b1; ops_addr[0] = 32'h04; ops_wdata[0] = 32'h1111_1111; ops_exp[0] = 32'd0;
    ops_we[1] = 1'b1; ops_addr[1] = 32'h08; ops_wdata[1] = 32'h2222_2222; ops_exp[1] = 32'd0;
    ops_we[2] = 1'b0; ops_addr[2] = 32'h04; ops_wdata[2] = 32'h0;         ops_exp[2] = 32'h1111_1111;
    ops_we[3] = 1'b0; ops_addr[3] = 32'h08; ops_wdata[3] = 32'h0;         ops_exp[3] = 32'h2222_2222;
    ops_we[4] = 1'b0; ops_addr[4] = 32'h04; ops_wdata[4] = 32'h0;         ops_exp[4] = 32'h1111_1111;
    @(negedge clk);
    ifb.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t6_ready", 32'(ifb.ready), 32'd1);
      ifb.req_we = ops_we[i];
      ifb.addr   = ops_addr[i];
      ifb.wdata  = ops_wdata[i];
      @(negedge clk);
      check("t6_resp", 32'(ifb.resp_valid), 32'd1);
      check("t6_busy", 32'(ifb.ready), 32'd0);
      check("t6_state", 32'(dbg_b), 32'd2);
      check("t6_err", 32'(ifb.err), 32'd0);
      check("t6_rdata", ifb.rdata, ops_exp[i]);
      @(negedge clk);
      check("t6_resp_off", 32'(ifb.resp_valid), 32'd0);
    end
    ifb.req_valid = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'(ifb.ready), 32'd1);
    check("t6_resp_idle", 32'(ifb.resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
